// File: rtl/keypad_pkg.sv
// Shared types, special key codes and the row/column to key-code map for the keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        PRESSED,
        RELEASE
    } state_t;

    localparam logic [3:0] KEY_STAR = 4'hE;
    localparam logic [3:0] KEY_HASH = 4'hF;

    // Physical layout: 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D
    function automatic logic [3:0] keymap(input logic [1:0] row_idx, input logic [1:0] col_idx);
        logic [3:0] code;
        code = 4'h0;
        case ({row_idx, col_idx})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;
            4'b00_11: code = 4'hA;
            4'b01_00: code = 4'h4;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;
            4'b01_11: code = 4'hB;
            4'b10_00: code = 4'h7;
            4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;
            4'b10_11: code = 4'hC;
            4'b11_00: code = KEY_STAR;
            4'b11_01: code = 4'h0;
            4'b11_10: code = KEY_HASH;
            4'b11_11: code = 4'hD;
            default:  code = 4'h0;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/keypad_entry.sv
// Digit accumulator: shifts in hex digits, '*' deletes the last one, '#' commits to key_data.
module keypad_entry
    import keypad_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        key_strobe,
    input  logic [3:0]  key_code,
    input  logic        rd_ack,
    output logic [15:0] entry,
    output logic [15:0] key_data,
    output logic        key_valid
);

    // Entry editing and commit; a commit in the same cycle as rd_ack leaves key_valid set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            entry     <= '0;
            key_data  <= '0;
            key_valid <= 1'b0;
        end else begin
            if (rd_ack) begin
                key_valid <= 1'b0;
            end
            if (key_strobe) begin
                case (key_code)
                    KEY_STAR: entry <= {4'h0, entry[15:4]};
                    KEY_HASH: begin
                        key_data  <= entry;
                        entry     <= '0;
                        key_valid <= 1'b1;
                    end
                    default:  entry <= {entry[11:0], key_code};
                endcase
            end
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: row scan, press/release debounce, key decode and entry accumulation.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV   = 50000,
    parameter int DEB_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  col,
    input  logic        rd_ack,
    output logic [3:0]  row,
    output logic [15:0] key_data,
    output logic        key_valid,
    output logic [15:0] entry,
    output logic [3:0]  key_code,
    output logic        key_strobe
);

    localparam int DW  = $clog2(SCAN_DIV);
    localparam int DBW = $clog2(DEB_CYCLES);
    localparam logic [DW-1:0]  DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [DBW-1:0] DEB_LAST   = DBW'(DEB_CYCLES - 1);

    logic [3:0]     col_s1;
    logic [3:0]     col_s;
    state_t         state;
    logic [1:0]     r_idx;
    logic [1:0]     c_idx;
    logic [1:0]     low_idx;
    logic [DW-1:0]  dwell_cnt;
    logic [DBW-1:0] deb_cnt;
    logic           armed;
    logic           accept;
    logic [3:0]     accept_code;

    // Two-flop synchronizer for the asynchronous, pulled-up column inputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_s1 <= '1;
            col_s  <= '1;
        end else begin
            col_s1 <= col;
            col_s  <= col_s1;
        end
    end

    // Active-low one-hot row drive and lowest-index low column.
    always_comb begin
        row = ~(4'b0001 << r_idx);
        casez (col_s)
            4'b???0: low_idx = 2'd0;
            4'b??01: low_idx = 2'd1;
            4'b?011: low_idx = 2'd2;
            default: low_idx = 2'd3;
        endcase
    end

    // The accept cycle is the first cycle in PRESSED; the accumulator updates on the same edge as key_strobe.
    always_comb begin
        accept      = (state == PRESSED) && armed;
        accept_code = keymap(r_idx, c_idx);
    end

    // Scan / debounce state machine with registered key_code and key_strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= SCAN;
            r_idx      <= '0;
            c_idx      <= '0;
            dwell_cnt  <= '0;
            deb_cnt    <= '0;
            armed      <= 1'b0;
            key_code   <= '0;
            key_strobe <= 1'b0;
        end else begin
            key_strobe <= 1'b0;
            case (state)
                SCAN: begin
                    if (dwell_cnt == DWELL_LAST) begin
                        dwell_cnt <= '0;
                        if (col_s != 4'b1111) begin
                            c_idx   <= low_idx;
                            deb_cnt <= '0;
                            state   <= DEBOUNCE;
                        end else begin
                            r_idx <= r_idx + 2'd1;
                        end
                    end else begin
                        dwell_cnt <= dwell_cnt + DW'(1);
                    end
                end
                DEBOUNCE: begin
                    if (col_s[c_idx]) begin
                        state     <= SCAN;
                        r_idx     <= r_idx + 2'd1;
                        dwell_cnt <= '0;
                    end else if (deb_cnt == DEB_LAST) begin
                        state <= PRESSED;
                        armed <= 1'b1;
                    end else begin
                        deb_cnt <= deb_cnt + DBW'(1);
                    end
                end
                PRESSED: begin
                    if (armed) begin
                        armed      <= 1'b0;
                        key_strobe <= 1'b1;
                        key_code   <= accept_code;
                    end
                    if (col_s == 4'b1111) begin
                        state   <= RELEASE;
                        deb_cnt <= '0;
                    end
                end
                RELEASE: begin
                    if (col_s != 4'b1111) begin
                        deb_cnt <= '0;
                    end else if (deb_cnt == DEB_LAST) begin
                        state     <= SCAN;
                        r_idx     <= r_idx + 2'd1;
                        dwell_cnt <= '0;
                    end else begin
                        deb_cnt <= deb_cnt + DBW'(1);
                    end
                end
                default: state <= SCAN;
            endcase
        end
    end

    keypad_entry u_entry (
        .clk        (clk),
        .rst        (rst),
        .key_strobe (accept),
        .key_code   (accept_code),
        .rd_ack     (rd_ack),
        .entry      (entry),
        .key_data   (key_data),
        .key_valid  (key_valid)
    );

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Scans a 4x4 matrix keypad, debounces press and release, and maps each key to a 4-bit code.
- Accumulates hex digits into a 16-bit entry register. '#' commits the entry to key_data; '*' deletes the last digit.
- key_data drives the IO block's keyboard_read_data, read by the CPU at IO addr 2'b11. entry is exposed for live display.

Parameters:
SCAN_DIV, 50000, row dwell in clk cycles per scanned row (>=2).
DEB_CYCLES, 1000000, consecutive stable cycles required to accept a press or a release (>=2).

Ports:
clk  in  1  system clock.
rst  in  1  asynchronous, active-low reset (asserted when 0).
col  in  4  keypad column inputs, active-low, pulled up; asynchronous to clk.
rd_ack  in  1  one-cycle pulse when the CPU has consumed key_data; clears key_valid.
row  out  4  keypad row drive, one-hot active-low.
key_data  out  16  last committed entry (to IO keyboard_read_data).
key_valid  out  1  sticky flag: committed value not yet acknowledged.
entry  out  16  live entry being typed.
key_code  out  4  code of the most recently accepted key.
key_strobe  out  1  one-cycle pulse when a key is accepted.

Behaviour:
- col passes through a 2-flop synchronizer (colS). All decisions below use colS.
- Reset (rst=0), all asynchronous:
  - state=SCAN, row index=0, row=4'b1110.
  - key_data=0, key_valid=0, entry=0, key_code=0, key_strobe=0, counters=0.
- State SCAN:
  - Drive row index r (row = ~(1<<r)). Dwell counter runs 0..SCAN_DIV-1.
  - On the last dwell cycle, if colS != 4'b1111: capture r and c. c is the lowest index with colS[c]=0. Go to DEBOUNCE with the row held.
  - Otherwise r <= r+1, wrapping 3->0.
- State DEBOUNCE:
  - Counter increments while colS[c]==0.
  - If colS[c]==1, return to SCAN and advance the row.
  - When the counter reaches DEB_CYCLES-1, go to PRESSED.
- Entry into PRESSED (single cycle): key_strobe=1, key_code=map(r,c), and the entry action is applied (see below).
- State PRESSED: hold until colS==4'b1111, then go to RELEASE with the counter cleared.
- State RELEASE:
  - Counter increments while colS==4'b1111. Any low column restarts the counter at 0 (no new strobe).
  - When the counter reaches DEB_CYCLES-1: go to SCAN, advance the row, reset the dwell counter.
- Key map, rows 0..3 by columns 0..3:
  - row0: 1 2 3 A
  - row1: 4 5 6 B
  - row2: 7 8 9 C
  - row3: E(*) 0 F(#) D
- Entry actions:
  - Codes 0-D: entry <= {entry[11:0], code}. The top nibble is discarded, so the entry wraps and keeps only the last 4 digits.
  - E (*): entry <= {4'h0, entry[15:4]}. Backspace on 0 leaves 0.
  - F (#): key_data <= entry, entry <= 0, key_valid <= 1. An overwrite while key_valid=1 is allowed; the flag stays 1.
- rd_ack clears key_valid on the next edge. If rd_ack and a commit occur in the same cycle, key_valid=1 (the set wins) and key_data takes the new value.
- Multiple keys pressed:
  - Only the captured (r,c) is tracked.
  - A second key pressed during PRESSED is ignored until all columns are released for DEB_CYCLES.
- Latency: a press stable from dwell-end produces key_strobe DEB_CYCLES+1 cycles after capture. key_data and entry update on the same edge as key_strobe.
- Counters are sized $clog2 of their parameter. Dwell and debounce counters are separate.

Decomposition:
- keypad_pkg holds:
  - State enum: SCAN, DEBOUNCE, PRESSED, RELEASE.
  - KEY_STAR=4'hE, KEY_HASH=4'hF.
  - Function keymap(row_idx, col_idx) returning the 4-bit code.
- Sub-module keypad_entry: the entry/key_data/key_valid accumulator.
  - Inputs: clk, rst, key_strobe, key_code, rd_ack.
  - Kept separate from the scan/debounce FSM in keypad_scanner.

Test Plan (SCAN_DIV=4, DEB_CYCLES=8):
1. Reset: hold rst=0 mid-scan -> row=4'b1110, key_data=0, key_valid=0, entry=0, key_strobe=0. Release rst -> row steps 1110,1101,1011,0111,1110 every 4 cycles.
2. Press row1/col2 (key 6), hold 20 cycles, release, then press 2, 5, #:
   - Exactly one key_strobe per key; key_code=6 on the first.
   - After '#', key_data=16'h0625, key_valid=1, entry=0.
3. Bounce: col pulses low for 3 cycles while row0 is driven -> no key_strobe, FSM returns to SCAN. Release bounce of 3-cycle lows -> RELEASE counter restarts, no second strobe.
4. Digits 1,2,3,4,5 then '*' -> entry goes 0x1234 -> 0x2345 -> 0x0234.
5. rd_ack with key_valid=1 -> key_valid=0 next cycle, key_data unchanged. rd_ack coincident with a '#' commit -> key_valid=1, key_data=new entry.
6. Hold keys 1 and 4 (row0/col0 and row1/col0) together -> only key 1 is accepted. No strobe for key 4 until all columns have been high for 8 cycles and it is re-pressed.
